intersection_phase_scheduler: RTL and testbench

- Multi-approach intersection scheduler that shares a single "green" right-of-way among N_APP approaches.
- Latches per-approach vehicle requests and grants green round-robin.
- Enforces minimum green, maximum green (when contested), yellow and all-red clearance times.
- Drives per-approach 2-bit lamp codes. It is the sequencing layer above the single-road highway/country signal controller.

---
 rtl/intersection_phase_scheduler.sv | 179 +++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: round-robin right-of-way sequencer for
// N_APP approaches with min/max green, yellow and all-red clearance.
module intersection_phase_scheduler #(
    parameter int N_APP       = 4,
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 12,
    parameter int YEL_TIME    = 3,
    parameter int ALLRED_TIME = 2,
    parameter int CNT_W       = 5,
    localparam int IDX_W      = (N_APP > 1) ? $clog2(N_APP) : 1
) (
    input  logic                 clck,
    input  logic                 clear,
    input  logic [N_APP-1:0]     req,
    output logic [2*N_APP-1:0]   lights,
    output logic [IDX_W-1:0]     active_idx,
    output logic                 green_on,
    output logic [N_APP-1:0]     pending
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } state_t;

    localparam logic [1:0] LAMP_G = 2'b00;
    localparam logic [1:0] LAMP_Y = 2'b10;

    localparam logic [CNT_W-1:0] MINC = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELC = CNT_W'(YEL_TIME - 1);
    localparam logic [CNT_W-1:0] ARC  = CNT_W'(ALLRED_TIME - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;

    logic [N_APP-1:0] dem;
    logic [N_APP-1:0] act_oh;
    logic [N_APP-1:0] others;
    logic [N_APP-1:0] grant;
    logic [N_APP-1:0] green_mask;
    logic [N_APP-1:0] pend_nxt;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] arb_ptr;
    logic [IDX_W-1:0] win;
    logic [CNT_W-1:0] cnt_sat;
    logic             ar_last;
    logic             grant_en;
    logic             leave_green;

    function automatic logic [IDX_W-1:0] idx_add(
        input logic [IDX_W-1:0] a,
        input int               k
    );
        int s;
        s = int'(a) + k;
        if (s >= N_APP) s = s - N_APP;
        return IDX_W'(s);
    endfunction

    function automatic logic [N_APP-1:0] onehot(input logic [IDX_W-1:0] a);
        logic [N_APP-1:0] v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    function automatic logic [2*N_APP-1:0] lamp_vec(
        input logic [IDX_W-1:0] a,
        input logic [1:0]       code
    );
        logic [2*N_APP-1:0] v;
        v = '1;
        for (int i = 0; i < N_APP; i++) begin
            if (IDX_W'(i) == a) v[2*i +: 2] = code;
        end
        return v;
    endfunction

    assign dem        = pending | req;
    assign act_oh     = onehot(active_idx);
    assign others     = dem & ~act_oh;
    assign ptr_nxt    = idx_add(active_idx, 1);
    assign ar_last    = (state == ALLRED) && (cnt == ARC);
    // the just-served approach drops to lowest priority at end of all-red
    assign arb_ptr    = (state == ALLRED) ? ptr_nxt : ptr;
    assign grant_en   = (|dem) && ((state == IDLE) || ar_last);
    assign grant      = grant_en ? onehot(win) : '0;
    assign green_mask = (state == GREEN) ? act_oh : '0;
    assign pend_nxt   = (pending | req) & ~grant & ~green_mask;
    assign cnt_sat    = (cnt == MAXC) ? cnt : cnt + 1'b1;
    assign leave_green = (cnt >= MINC) && (|others) &&
                         (!req[active_idx] || (cnt == MAXC));

    // round-robin search of the demand vector starting at arb_ptr
    always_comb begin : arb
        logic             hit;
        logic [IDX_W-1:0] c;
        hit = 1'b0;
        c   = '0;
        win = '0;
        for (int k = 0; k < N_APP; k++) begin
            c = idx_add(arb_ptr, k);
            if (!hit && dem[c]) begin
                hit = 1'b1;
                win = c;
            end
        end
    end

    // phase sequencer with registered lamps, index and request latch
    always_ff @(posedge clck) begin
        if (clear) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            active_idx <= '0;
            lights     <= '1;
            green_on   <= 1'b0;
            pending    <= '0;
        end else begin
            pending <= pend_nxt;
            unique case (state)
                IDLE: begin
                    if (|dem) begin
                        state      <= GREEN;
                        active_idx <= win;
                        cnt        <= '0;
                        lights     <= lamp_vec(win, LAMP_G);
                        green_on   <= 1'b1;
                    end
                end
                GREEN: begin
                    if (leave_green) begin
                        state    <= YELLOW;
                        cnt      <= '0;
                        lights   <= lamp_vec(active_idx, LAMP_Y);
                        green_on <= 1'b0;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                YELLOW: begin
                    if (cnt == YELC) begin
                        state  <= ALLRED;
                        cnt    <= '0;
                        lights <= '1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ALLRED: begin
                    if (ar_last) begin
                        ptr <= ptr_nxt;
                        cnt <= '0;
                        if (|dem) begin
                            state      <= GREEN;
                            active_idx <= win;
                            lights     <= lamp_vec(win, LAMP_G);
                            green_on   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    lights <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: directed vectors feed a scoreboard
// queue; a negedge monitor pops and compares, plus lamp invariants.
module tb_intersection_phase_scheduler;

    logic       clck = 1'b0;
    logic       clear;
    logic [3:0] req;
    logic [7:0] lights;
    logic [1:0] active_idx;
    logic       green_on;
    logic [3:0] pending;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] l;
        logic [1:0] i;
        logic       g;
        logic [3:0] p;
    } exp_t;

    exp_t  sb[$];
    int    cyc    = 0;
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    inv_en = 1'b0;
    string tname  = "reset";

    intersection_phase_scheduler #(
        .N_APP(4), .MIN_GREEN(4), .MAX_GREEN(12),
        .YEL_TIME(3), .ALLRED_TIME(2), .CNT_W(5)
    ) dut (
        .clck(clck), .clear(clear), .req(req), .lights(lights),
        .active_idx(active_idx), .green_on(green_on), .pending(pending)
    );

    always #5 clck = ~clck;

    always @(posedge clck) cyc <= cyc + 1;

    function automatic logic [7:0] lamp(input int a, input logic [1:0] code);
        logic [7:0] v;
        v = 8'hFF;
        v[2*a +: 2] = code;
        return v;
    endfunction

    task automatic tick();
        @(posedge clck);
        #1;
    endtask

    task automatic push(input logic [7:0] l, input logic [1:0] i,
                        input logic g, input logic [3:0] p);
        exp_t e;
        e.cyc  = cyc;
        e.name = tname;
        e.l    = l;
        e.i    = i;
        e.g    = g;
        e.p    = p;
        sb.push_back(e);
    endtask

    // advance one cycle, expect outputs, then set req for the next edge
    task automatic vec(input logic [3:0] r, input logic [7:0] l,
                       input logic [1:0] i, input logic g,
                       input logic [3:0] p);
        tick();
        push(l, i, g, p);
        req = r;
    endtask

    task automatic do_reset(input int n, input logic [3:0] rd,
                            input logic [3:0] ra);
        clear = 1'b1;
        req   = rd;
        repeat (n) begin
            tick();
            push(8'hFF, 2'd0, 1'b0, 4'h0);
        end
        clear  = 1'b0;
        req    = ra;
        inv_en = 1'b1;
    endtask

    initial begin : mon
        exp_t e;
        int   nr;
        bit   gs;
        forever begin
            @(negedge clck);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (e.cyc != cyc || lights !== e.l || active_idx !== e.i ||
                    green_on !== e.g || pending !== e.p) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d (exp for %0d): got lights=%h idx=%0d gon=%b pend=%b, want lights=%h idx=%0d gon=%b pend=%b",
                             e.name, cyc, e.cyc, lights, active_idx, green_on,
                             pending, e.l, e.i, e.g, e.p);
                end
            end
            if (inv_en) begin
                nr = 0;
                gs = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (lights[2*i +: 2] !== 2'b11) nr++;
                    if (lights[2*i +: 2] === 2'b00) gs = 1'b1;
                end
                n_chk++;
                if (nr > 1 || green_on !== gs) begin
                    n_fail++;
                    $display("FAIL lamp_invariant cyc %0d: got lights=%h gon=%b, want at most one non-red and gon=%b",
                             cyc, lights, green_on, gs);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] rest;
        clear = 1'b1;
        req   = 4'h0;

        tname = "reset";
        do_reset(2, 4'hF, 4'h0);

        tname = "single";
        vec(4'b0100, 8'hFF, 2'd0, 1'b0, 4'h0);
        vec(4'b0000, 8'hCF, 2'd2, 1'b1, 4'h0);
        repeat (40) vec(4'b0000, 8'hCF, 2'd2, 1'b1, 4'h0);

        tname = "early_release";
        do_reset(1, 4'h0, 4'h0);
        vec(4'b0001, 8'hFF, 2'd0, 1'b0, 4'h0);
        vec(4'b0000, 8'hFC, 2'd0, 1'b1, 4'h0);
        vec(4'b0100, 8'hFC, 2'd0, 1'b1, 4'h0);
        vec(4'b0000, 8'hFC, 2'd0, 1'b1, 4'b0100);
        vec(4'b0000, 8'hFC, 2'd0, 1'b1, 4'b0100);
        repeat (3) vec(4'b0000, 8'hFE, 2'd0, 1'b0, 4'b0100);
        repeat (2) vec(4'b0000, 8'hFF, 2'd0, 1'b0, 4'b0100);
        repeat (2) vec(4'b0000, 8'hCF, 2'd2, 1'b1, 4'h0);

        tname = "max_green";
        do_reset(1, 4'h0, 4'h0);
        vec(4'b0001, 8'hFF, 2'd0, 1'b0, 4'h0);
        vec(4'b0011, 8'hFC, 2'd0, 1'b1, 4'h0);
        repeat (11) vec(4'b0001, 8'hFC, 2'd0, 1'b1, 4'b0010);
        vec(4'b0001, 8'hFE, 2'd0, 1'b0, 4'b0010);
        repeat (2) vec(4'b0001, 8'hFE, 2'd0, 1'b0, 4'b0011);
        repeat (2) vec(4'b0001, 8'hFF, 2'd0, 1'b0, 4'b0011);
        repeat (4) vec(4'b0001, 8'hF3, 2'd1, 1'b1, 4'b0001);

        tname = "round_robin";
        do_reset(1, 4'h0, 4'hF);
        for (int ph = 0; ph < 5; ph++) begin
            rest = 4'hF & ~(4'b0001 << (ph % 4));
            repeat (12)
                vec(4'hF, lamp(ph % 4, 2'b00), 2'(ph % 4), 1'b1, rest);
            vec(4'hF, lamp(ph % 4, 2'b10), 2'(ph % 4), 1'b0, rest);
            repeat (2)
                vec(4'hF, lamp(ph % 4, 2'b10), 2'(ph % 4), 1'b0, 4'hF);
            repeat (2)
                vec(4'hF, 8'hFF, 2'(ph % 4), 1'b0, 4'hF);
        end

        tname = "mid_reset";
        do_reset(1, 4'h0, 4'h0);
        vec(4'b0001, 8'hFF, 2'd0, 1'b0, 4'h0);
        vec(4'b1011, 8'hFC, 2'd0, 1'b1, 4'h0);
        repeat (3) vec(4'b0000, 8'hFC, 2'd0, 1'b1, 4'b1010);
        repeat (2) vec(4'b0000, 8'hFE, 2'd0, 1'b0, 4'b1010);
        do_reset(1, 4'b1010, 4'b1010);
        vec(4'b0000, 8'hF3, 2'd1, 1'b1, 4'b1000);
        repeat (2) vec(4'b0000, 8'hF3, 2'd1, 1'b1, 4'b1000);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clck);
        @(posedge clck);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0",
                     sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
